genfifo_credit_buffer: RTL and testbench

- Elastic buffer placed on a genfifo req/ack link, e.g. between the taylor_pipeline output and an external consumer.
- Upstream side is the responder: it accepts req/wdata and drives ack. Downstream side is the initiator: it drives req/rdata and samples ack.
- Publishes free-slot credits so a producer can throttle ahead of backpressure.
- Optional statistics counters for throughput/stall analysis in simulation and bring-up.

---
 rtl/genfifo_credit_buffer.sv | 117 +++++++++++
 tb/tb_genfifo_credit_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/genfifo_credit_buffer.sv
// genfifo_credit_buffer: elastic FIFO for a genfifo req/ack link.
// The upstream side accepts words and the downstream side offers the head entry.
// count_bo reports occupancy and credit_bo reports free slots so a producer can
// throttle early.
// Optional macro GENFIFO_CREDIT_STATS_EN adds 32-bit transfer and stall counters.
module genfifo_credit_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_genfifo_req_i,
  input  logic [WIDTH-1:0] in_genfifo_wdata_bi,
  output logic             in_genfifo_ack_o,
  output logic             out_genfifo_req_o,
  output logic [WIDTH-1:0] out_genfifo_rdata_bo,
  input  logic             out_genfifo_ack_i,
  output logic [CW-1:0]    count_bo,
  output logic [CW-1:0]    credit_bo
`ifdef GENFIFO_CREDIT_STATS_EN
  ,
  output logic [31:0]      stat_in_xfers_bo,
  output logic [31:0]      stat_out_xfers_bo,
  output logic [31:0]      stat_full_stall_bo,
  output logic [31:0]      stat_out_stall_bo
`endif
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Handshakes depend only on registered occupancy; a full buffer refuses
  // input even when the head is popped in the same cycle.
  assign full                 = (count == FULL_CNT);
  assign empty                = (count == '0);
  assign in_genfifo_ack_o     = in_genfifo_req_i && !full;
  assign out_genfifo_req_o    = !empty;
  assign push                 = in_genfifo_req_i && !full;
  assign pop                  = !empty && out_genfifo_ack_i;
  assign out_genfifo_rdata_bo = mem[rd_ptr];
  assign count_bo             = count;
  assign credit_bo            = FULL_CNT - count;

  // Storage: cleared on reset so the head reads zero after a reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= in_genfifo_wdata_bi;
    end
  end

  // Pointer and occupancy tracking; a push and pop together leave count alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef GENFIFO_CREDIT_STATS_EN
  // Free-running statistics; wrap naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_in_xfers_bo   <= '0;
      stat_out_xfers_bo  <= '0;
      stat_full_stall_bo <= '0;
      stat_out_stall_bo  <= '0;
    end else begin
      if (push) begin
        stat_in_xfers_bo <= stat_in_xfers_bo + 32'd1;
      end
      if (pop) begin
        stat_out_xfers_bo <= stat_out_xfers_bo + 32'd1;
      end
      if (in_genfifo_req_i && full) begin
        stat_full_stall_bo <= stat_full_stall_bo + 32'd1;
      end
      if (!empty && !out_genfifo_ack_i) begin
        stat_out_stall_bo <= stat_out_stall_bo + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_genfifo_credit_buffer.sv
// Testbench for genfifo_credit_buffer: directed vector table, hand-written
// reset sequences and a randomized stream against a queue-based model,
// on DEPTH=4 and DEPTH=3 instances.
module tb_genfifo_credit_buffer;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req;
  logic         oack;
  logic [W-1:0] wd;

  logic         ack4, oreq4;
  logic [W-1:0] rd4;
  logic [2:0]   cnt4, cr4;
  logic         ack3, oreq3;
  logic [W-1:0] rd3;
  logic [1:0]   cnt3, cr3;
`ifdef GENFIFO_CREDIT_STATS_EN
  logic [31:0]  s4_in, s4_out, s4_fs, s4_os;
  logic [31:0]  s3_in, s3_out, s3_fs, s3_os;
`endif

  genfifo_credit_buffer #(.WIDTH(W), .DEPTH(4)) dut4 (
    .clk_i                (clk),
    .rst_i                (rst),
    .in_genfifo_req_i     (req),
    .in_genfifo_wdata_bi  (wd),
    .in_genfifo_ack_o     (ack4),
    .out_genfifo_req_o    (oreq4),
    .out_genfifo_rdata_bo (rd4),
    .out_genfifo_ack_i    (oack),
    .count_bo             (cnt4),
    .credit_bo            (cr4)
`ifdef GENFIFO_CREDIT_STATS_EN
    ,
    .stat_in_xfers_bo     (s4_in),
    .stat_out_xfers_bo    (s4_out),
    .stat_full_stall_bo   (s4_fs),
    .stat_out_stall_bo    (s4_os)
`endif
  );

  genfifo_credit_buffer #(.WIDTH(W), .DEPTH(3)) dut3 (
    .clk_i                (clk),
    .rst_i                (rst),
    .in_genfifo_req_i     (req),
    .in_genfifo_wdata_bi  (wd),
    .in_genfifo_ack_o     (ack3),
    .out_genfifo_req_o    (oreq3),
    .out_genfifo_rdata_bo (rd3),
    .out_genfifo_ack_i    (oack),
    .count_bo             (cnt3),
    .credit_bo            (cr3)
`ifdef GENFIFO_CREDIT_STATS_EN
    ,
    .stat_in_xfers_bo     (s3_in),
    .stat_out_xfers_bo    (s3_out),
    .stat_full_stall_bo   (s3_fs),
    .stat_out_stall_bo    (s3_os)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: apply inputs just after an edge, then wait for the next edge.
  task automatic tick(input logic r, input logic [W-1:0] d, input logic a);
    req  = r;
    wd   = d;
    oack = a;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         req;
    logic [W-1:0] wd;
    logic         oack;
    logic         e_ack;
    logic         e_oreq;
    logic [W-1:0] e_rd;
    int           e_cnt;
  } vec_t;

  vec_t tbl[20];

  logic [W-1:0] q4[$];
  logic [W-1:0] q3[$];
  logic [W-1:0] nxt;
  int           pct;
  logic         e_ack4, e_oreq4, e_ack3, e_oreq3;

  initial begin
    // inputs applied, then outputs expected before the following edge
    tbl[0]  = '{1'b1, 16'd1,    1'b0, 1'b1, 1'b0, 16'd0,    0};
    tbl[1]  = '{1'b1, 16'd2,    1'b0, 1'b1, 1'b1, 16'd1,    1};
    tbl[2]  = '{1'b1, 16'd3,    1'b0, 1'b1, 1'b1, 16'd1,    2};
    tbl[3]  = '{1'b1, 16'd4,    1'b0, 1'b1, 1'b1, 16'd1,    3};
    tbl[4]  = '{1'b1, 16'd5,    1'b0, 1'b0, 1'b1, 16'd1,    4};
    tbl[5]  = '{1'b1, 16'd5,    1'b1, 1'b0, 1'b1, 16'd1,    4};
    tbl[6]  = '{1'b1, 16'd5,    1'b1, 1'b1, 1'b1, 16'd2,    3};
    tbl[7]  = '{1'b1, 16'd6,    1'b1, 1'b1, 1'b1, 16'd3,    3};
    tbl[8]  = '{1'b1, 16'd7,    1'b1, 1'b1, 1'b1, 16'd4,    3};
    tbl[9]  = '{1'b1, 16'd8,    1'b1, 1'b1, 1'b1, 16'd5,    3};
    tbl[10] = '{1'b1, 16'd9,    1'b1, 1'b1, 1'b1, 16'd6,    3};
    tbl[11] = '{1'b1, 16'd10,   1'b1, 1'b1, 1'b1, 16'd7,    3};
    tbl[12] = '{1'b1, 16'd11,   1'b1, 1'b1, 1'b1, 16'd8,    3};
    tbl[13] = '{1'b0, 16'd0,    1'b1, 1'b0, 1'b1, 16'd9,    3};
    tbl[14] = '{1'b0, 16'd0,    1'b1, 1'b0, 1'b1, 16'd10,   2};
    tbl[15] = '{1'b0, 16'd0,    1'b1, 1'b0, 1'b1, 16'd11,   1};
    tbl[16] = '{1'b0, 16'd0,    1'b1, 1'b0, 1'b0, 16'd0,    0};
    tbl[17] = '{1'b1, 16'h00AA, 1'b0, 1'b1, 1'b0, 16'd0,    0};
    tbl[18] = '{1'b0, 16'd0,    1'b1, 1'b0, 1'b1, 16'h00AA, 1};
    tbl[19] = '{1'b0, 16'd0,    1'b0, 1'b0, 1'b0, 16'd0,    0};

    rst = 1'b1; req = 1'b1; oack = 1'b0; wd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table on the DEPTH=4 instance
    for (int i = 0; i < 20; i++) begin
      req  = tbl[i].req;
      wd   = tbl[i].wd;
      oack = tbl[i].oack;
      @(negedge clk);
      check($sformatf("tbl%0d_in_ack", i), 64'(ack4), 64'(tbl[i].e_ack));
      check($sformatf("tbl%0d_out_req", i), 64'(oreq4), 64'(tbl[i].e_oreq));
      check($sformatf("tbl%0d_count", i), 64'(cnt4), 64'(tbl[i].e_cnt));
      check($sformatf("tbl%0d_credit", i), 64'(cr4), 64'(4 - tbl[i].e_cnt));
      if (tbl[i].e_oreq) check($sformatf("tbl%0d_rdata", i), 64'(rd4), 64'(tbl[i].e_rd));
      @(posedge clk);
      #1;
    end

    // Reset mid-stream: contents discarded, pointers restart at zero
    tick(1'b1, 16'h0011, 1'b0);
    tick(1'b1, 16'h0022, 1'b0);
    tick(1'b1, 16'h0033, 1'b0);
    tick(1'b0, 16'h0000, 1'b1);
    check("pre_rst_count", 64'(cnt4), 64'd2);
    check("pre_rst_head", 64'(rd4), 64'h22);
    rst = 1'b1;
    tick(1'b1, 16'h0055, 1'b1);
    rst = 1'b0;
    req = 1'b1; wd = 16'h0044; oack = 1'b0;
    @(negedge clk);
    check("rst_count", 64'(cnt4), 64'd0);
    check("rst_credit", 64'(cr4), 64'd4);
    check("rst_out_req", 64'(oreq4), 64'd0);
    check("rst_rdata", 64'(rd4), 64'd0);
    check("rst_in_ack", 64'(ack4), 64'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    check("post_rst_head", 64'(rd4), 64'h44);
    check("post_rst_count", 64'(cnt4), 64'd1);

`ifdef GENFIFO_CREDIT_STATS_EN
    rst = 1'b1;
    tick(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    repeat (3) tick(1'b1, 16'h0007, 1'b0);
    repeat (2) tick(1'b0, 16'h0000, 1'b0);
    repeat (3) tick(1'b0, 16'h0000, 1'b1);
    check("stat_in_a", 64'(s4_in), 64'd3);
    check("stat_out_a", 64'(s4_out), 64'd3);
    check("stat_os_a", 64'(s4_os), 64'd4);
    check("stat_fs_a", 64'(s4_fs), 64'd0);
    repeat (5) tick(1'b1, 16'h0009, 1'b0);
    check("stat_in_b", 64'(s4_in), 64'd7);
    check("stat_fs_b", 64'(s4_fs), 64'd1);
    check("stat_os_b", 64'(s4_os), 64'd8);
    repeat (2) tick(1'b0, 16'h0000, 1'b1);
    check("stat_count_mid", 64'(cnt4), 64'd2);
    rst = 1'b1;
    tick(1'b1, 16'h0001, 1'b1);
    rst = 1'b0;
    req = 1'b0; oack = 1'b0;
    #1;
    check("stat_rst_in", 64'(s4_in), 64'd0);
    check("stat_rst_out", 64'(s4_out), 64'd0);
    check("stat_rst_fs", 64'(s4_fs), 64'd0);
    check("stat_rst_os", 64'(s4_os), 64'd0);
    check("stat_rst_count", 64'(cnt4), 64'd0);
    check("stat3_rst_sum", 64'(s3_in) + 64'(s3_out) + 64'(s3_fs) + 64'(s3_os), 64'd0);
`endif

    // Randomized stream against queue models for both depths
    rst = 1'b1;
    tick(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    q4.delete();
    q3.delete();
    nxt = 16'd1;
    for (int i = 0; i < 4000; i++) begin
      case (i / 1000)
        0: pct = 10;
        1: pct = 50;
        2: pct = 90;
        default: pct = 10;
      endcase
      req  = ($urandom_range(0, 9) != 0);
      wd   = nxt;
      oack = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      e_ack4  = req && (q4.size() != 4);
      e_oreq4 = (q4.size() != 0);
      e_ack3  = req && (q3.size() != 3);
      e_oreq3 = (q3.size() != 0);
      check("rnd4_in_ack", 64'(ack4), 64'(e_ack4));
      check("rnd4_out_req", 64'(oreq4), 64'(e_oreq4));
      check("rnd4_count", 64'(cnt4), 64'(q4.size()));
      check("rnd4_sum", 64'(cnt4) + 64'(cr4), 64'd4);
      if (e_oreq4) check("rnd4_rdata", 64'(rd4), 64'(q4[0]));
      check("rnd3_in_ack", 64'(ack3), 64'(e_ack3));
      check("rnd3_out_req", 64'(oreq3), 64'(e_oreq3));
      check("rnd3_count", 64'(cnt3), 64'(q3.size()));
      check("rnd3_sum", 64'(cnt3) + 64'(cr3), 64'd3);
      if (e_oreq3) check("rnd3_rdata", 64'(rd3), 64'(q3[0]));
      @(posedge clk);
      if (e_oreq4 && oack) void'(q4.pop_front());
      if (e_ack4) q4.push_back(wd);
      if (e_oreq3 && oack) void'(q3.pop_front());
      if (e_ack3) q3.push_back(wd);
      if (e_ack4) nxt = (nxt == 16'd400) ? 16'd1 : nxt + 16'd1;
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
